uart_stream_buffer: RTL and testbench

//  Byte-stream front end for uart_controller.
//  - TX FIFO: core-side valid/ready pushes are drained into the controller's send/send_busy handshake.
//  - RX FIFO: captures rev_data on rev_data_valid, acks it via rev_data_invalid, presents bytes FWFT.
//  - Decouples core timing from UART bit timing; flags receive overrun.

---
 rtl/uart_stream_if.sv | 30 +++
 rtl/uart_stream_buffer.sv | 143 ++++++++++++++
 tb/tb_uart_stream_buffer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_if.sv
// Core-side byte-stream interface of uart_stream_buffer.
// TX push handshake, FWFT RX pop handshake, occupancy and overrun status.
interface uart_stream_if #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [TX_CW-1:0] tx_count;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [RX_CW-1:0] rx_count;
    logic             rx_overrun;
    logic             overrun_clear;

    modport master (
        output tx_data, tx_valid, rx_ready, overrun_clear,
        input  tx_ready, tx_count, rx_data, rx_valid, rx_count, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, overrun_clear,
        output tx_ready, tx_count, rx_data, rx_valid, rx_count, rx_overrun
    );
endinterface

// File: rtl/uart_stream_buffer.sv
// Byte-stream front end for uart_controller: TX FIFO drained through the
// send/send_busy handshake, RX FIFO fed by rev_data_valid with sticky overrun.
module uart_stream_buffer #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_stream_if.slave core,
    output logic [7:0]  send_data,
    output logic        send,
    input  logic        send_busy,
    input  logic [7:0]  rev_data,
    input  logic        rev_data_valid,
    output logic        rev_data_invalid
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_cnt;
    logic             tx_not_full, tx_push, tx_pop;

    assign tx_not_full   = (tx_cnt != TX_CW'(TX_DEPTH));
    assign tx_push       = core.tx_valid && tx_not_full;
    assign core.tx_ready = tx_not_full;
    assign core.tx_count = tx_cnt;

    // NOTE: storage arrays carry no reset; pointers and counts alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= core.tx_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
                2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- TX issue FSM ----------------
    tx_state_e  tx_state, tx_state_nxt;
    logic       send_nxt;
    logic [7:0] send_data_nxt;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        tx_state_nxt  = tx_state;
        send_nxt      = 1'b0;
        send_data_nxt = send_data;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                // Waiting on !send_busy also keeps a frame in flight across reset from being re-triggered.
                if (tx_cnt != '0 && !send_busy) begin
                    send_nxt      = 1'b1;
                    send_data_nxt = tx_mem[tx_rd_ptr];
                    tx_pop        = 1'b1;
                    tx_state_nxt  = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: if (send_busy)  tx_state_nxt = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!send_busy) tx_state_nxt = TX_IDLE;
            default:                      tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            send      <= 1'b0;
            send_data <= '0;
        end else begin
            tx_state  <= tx_state_nxt;
            send      <= send_nxt;
            send_data <= send_data_nxt;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_cnt;
    logic             rx_full, rx_not_empty, rx_pop, rx_capture, rx_push, rx_drop;

    assign rx_full      = (rx_cnt == RX_CW'(RX_DEPTH));
    assign rx_not_empty = (rx_cnt != '0);
    assign rx_pop       = rx_not_empty && core.rx_ready;
    // The ack cycle masks capture, so a valid held into it is not taken twice.
    assign rx_capture   = rev_data_valid && !rev_data_invalid;
    assign rx_push      = rx_capture && (!rx_full || rx_pop);
    assign rx_drop      = rx_capture && rx_full && !rx_pop;

    assign core.rx_data  = rx_mem[rx_rd_ptr];
    assign core.rx_valid = rx_not_empty;
    assign core.rx_count = rx_cnt;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rev_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr        <= '0;
            rx_rd_ptr        <= '0;
            rx_cnt           <= '0;
            rev_data_invalid <= 1'b0;
            core.rx_overrun  <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
                2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
            rev_data_invalid <= rx_capture;
            // A drop in the same cycle as a clear request wins.
            if (rx_drop)                 core.rx_overrun <= 1'b1;
            else if (core.overrun_clear) core.rx_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_stream_buffer.sv
// Self-checking bench for uart_stream_buffer: queue-based reference model
// compared every cycle, plus directed checks with hand-computed values.
module tb_uart_stream_buffer;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_stream_if #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) sif ();

    logic [7:0] send_data;
    logic       send;
    logic       send_busy;
    logic [7:0] rev_data = 8'h00;
    logic       rev_data_valid = 1'b0;
    logic       rev_data_invalid;

    uart_stream_buffer #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .core             (sif),
        .send_data        (send_data),
        .send             (send),
        .send_busy        (send_busy),
        .rev_data         (rev_data),
        .rev_data_valid   (rev_data_valid),
        .rev_data_invalid (rev_data_invalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: busy rises one cycle after send is seen, lasts busy_len cycles.
    logic ctrl_hold = 1'b0, ctrl_busy = 1'b0, ctrl_start = 1'b0;
    int   busy_left = 0;
    bit   rand_busy = 1'b0;
    assign send_busy = ctrl_hold || ctrl_busy;

    always @(negedge clk) begin
        if (ctrl_start) begin
            ctrl_start = 1'b0;
            ctrl_busy  = 1'b1;
            busy_left  = rand_busy ? int'($urandom_range(1, 12)) : 10;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) ctrl_busy = 1'b0;
        end
        if (send === 1'b1) ctrl_start = 1'b1;
    end

    // Reference model: queues for both FIFOs, handshake progress as two flags.
    logic [7:0] m_tx_q[$];
    logic [7:0] m_rx_q[$];
    bit         m_wait_rise = 0, m_wait_fall = 0;
    bit         m_send = 0, m_invalid = 0, m_overrun = 0;
    logic [7:0] m_send_data = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        bit issue, tx_acc, cap, take, full;
        if (!rst_n) begin
            m_tx_q.delete();
            m_rx_q.delete();
            m_wait_rise = 0; m_wait_fall = 0;
            m_send = 0; m_invalid = 0; m_overrun = 0;
            m_send_data = 8'h00;
        end else begin
            issue  = !m_wait_rise && !m_wait_fall && m_tx_q.size() != 0 && !send_busy;
            tx_acc = sif.tx_valid && m_tx_q.size() < TX_DEPTH;
            if (m_wait_rise && send_busy) begin
                m_wait_rise = 0;
                m_wait_fall = 1;
            end else if (m_wait_fall && !send_busy) begin
                m_wait_fall = 0;
            end
            m_send = issue;
            if (issue) begin
                m_send_data = m_tx_q.pop_front();
                m_wait_rise = 1;
            end
            if (tx_acc) m_tx_q.push_back(sif.tx_data);

            cap  = rev_data_valid && !m_invalid;
            take = sif.rx_ready && m_rx_q.size() != 0;
            full = m_rx_q.size() == RX_DEPTH;
            if (take) void'(m_rx_q.pop_front());
            if (cap && (!full || take)) m_rx_q.push_back(rev_data);
            if (cap && full && !take) m_overrun = 1;
            else if (sif.overrun_clear) m_overrun = 0;
            m_invalid = cap;
        end
    end

    // Compare process and monitors, sampled mid-cycle.
    bit         cmp_en = 0;
    logic [7:0] sent_q[$];
    int         inv_pulses = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx_count", 32'(sif.tx_count), m_tx_q.size());
            check("tx_ready", 32'(sif.tx_ready), 32'(m_tx_q.size() < TX_DEPTH));
            check("rx_count", 32'(sif.rx_count), m_rx_q.size());
            check("rx_valid", 32'(sif.rx_valid), 32'(m_rx_q.size() != 0));
            if (m_rx_q.size() != 0) check("rx_data", 32'(sif.rx_data), 32'(m_rx_q[0]));
            check("rx_overrun", 32'(sif.rx_overrun), 32'(m_overrun));
            check("send", 32'(send), 32'(m_send));
            check("send_data", 32'(send_data), 32'(m_send_data));
            check("rev_data_invalid", 32'(rev_data_invalid), 32'(m_invalid));
            if (send === 1'b1) sent_q.push_back(send_data);
            if (rev_data_invalid === 1'b1) inv_pulses++;
        end
    end

    // Stimulus helpers, all entered and left at #1 after a rising edge.
    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        sif.tx_data  = b;
        sif.tx_valid = 1'b1;
        while (!sif.tx_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_timeout", 32'(n >= 300), 0);
        @(posedge clk); #1;
        sif.tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while ((sif.tx_count != 0 || send_busy || send || ctrl_start) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 32'(n >= 500), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int hold);
        rev_data       = b;
        rev_data_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        rev_data_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int cycles, input int rdy_pct);
        fork
            begin
                for (int c = 0; c < cycles; c++) begin
                    sif.tx_valid      = ($urandom % 3) == 0;
                    sif.tx_data       = 8'($urandom);
                    sif.rx_ready      = $urandom_range(0, 99) < rdy_pct;
                    sif.overrun_clear = ($urandom % 40) == 0;
                    @(posedge clk); #1;
                end
            end
            begin
                for (int c = 0; c < cycles; c++) begin
                    if (rev_data_valid && rev_data_invalid) begin
                        rev_data_valid = 1'b0;
                    end else if (!rev_data_valid && ($urandom % 3) == 0) begin
                        rev_data       = 8'($urandom);
                        rev_data_valid = 1'b1;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        sif.tx_valid      = 1'b0;
        sif.rx_ready      = 1'b0;
        sif.overrun_clear = 1'b0;
        rev_data_valid    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int inv0;
        logic [31:0] exp_b;
        sif.tx_data = 8'h00; sif.tx_valid = 1'b0;
        sif.rx_ready = 1'b0; sif.overrun_clear = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        check("rst_tx_ready", 32'(sif.tx_ready), 1);
        check("rst_rx_valid", 32'(sif.rx_valid), 0);
        check("rst_send", 32'(send), 0);
        check("rst_send_data", 32'(send_data), 0);
        check("rst_tx_count", 32'(sif.tx_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: push at edge N, send high N+1..N+2
        push_tx(8'hA5);
        @(negedge clk);
        check("single_count_pushed", 32'(sif.tx_count), 1);
        check("single_send_early", 32'(send), 0);
        @(negedge clk);
        check("single_send", 32'(send), 1);
        check("single_send_data", 32'(send_data), 32'hA5);
        check("single_count_popped", 32'(sif.tx_count), 0);
        @(negedge clk);
        check("single_send_one_cycle", 32'(send), 0);
        check("single_data_held", 32'(send_data), 32'hA5);
        @(posedge clk); #1;
        wait_tx_idle();

        // Burst: fill while controller is held busy, then drain in order
        sent_q.delete();
        ctrl_hold = 1'b1;
        for (int i = 0; i < 16; i++) push_tx(8'(i));
        check("burst_full_count", 32'(sif.tx_count), 16);
        check("burst_full_ready", 32'(sif.tx_ready), 0);
        sif.tx_data  = 8'hEE;
        sif.tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sif.tx_valid = 1'b0;
        check("burst_no_push_full", 32'(sif.tx_count), 16);
        ctrl_hold = 1'b0;
        wait_tx_idle();
        check("burst_sent_n", sent_q.size(), 16);
        for (int i = 0; i < 16 && i < sent_q.size(); i++)
            check("burst_order", 32'(sent_q[i]), i);

        // RX single byte with valid held two cycles
        inv0 = inv_pulses;
        rx_byte(8'h3C, 2);
        check("rx_one_ack", inv_pulses - inv0, 1);
        check("rx_valid", 32'(sif.rx_valid), 1);
        check("rx_data_3c", 32'(sif.rx_data), 32'h3C);
        check("rx_count_one", 32'(sif.rx_count), 1);
        sif.rx_ready = 1'b1;
        @(posedge clk); #1;
        sif.rx_ready = 1'b0;
        check("rx_popped", 32'(sif.rx_count), 0);

        // Overrun: 17 bytes without consumer
        for (int i = 0; i < 17; i++) rx_byte(8'(i), 1);
        check("ovr_count", 32'(sif.rx_count), 16);
        check("ovr_flag", 32'(sif.rx_overrun), 1);
        check("ovr_head", 32'(sif.rx_data), 0);
        sif.overrun_clear = 1'b1;
        @(posedge clk); #1;
        sif.overrun_clear = 1'b0;
        check("ovr_cleared", 32'(sif.rx_overrun), 0);

        // Full FIFO with pop on the arrival edge: byte accepted
        rev_data = 8'h77; rev_data_valid = 1'b1; sif.rx_ready = 1'b1;
        @(posedge clk); #1;
        rev_data_valid = 1'b0; sif.rx_ready = 1'b0;
        check("fullpop_count", 32'(sif.rx_count), 16);
        check("fullpop_no_ovr", 32'(sif.rx_overrun), 0);
        check("fullpop_ack", 32'(rev_data_invalid), 1);
        @(posedge clk); #1;
        sif.rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_b = (i < 15) ? 32'(i + 1) : 32'h77;
            check("drain_byte", 32'(sif.rx_data), exp_b);
        end
        @(posedge clk); #1;
        sif.rx_ready = 1'b0;
        check("drain_empty", 32'(sif.rx_count), 0);

        // Randomized traffic, slow consumer to provoke overruns
        rand_busy = 1'b1;
        run_random(1500, 25);

        // Reset mid-stream
        sif.tx_valid = 1'b1; sif.tx_data = 8'h5A;
        rev_data = 8'h11; rev_data_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_ready", 32'(sif.tx_ready), 1);
        check("mid_rst_rx_valid", 32'(sif.rx_valid), 0);
        check("mid_rst_send", 32'(send), 0);
        check("mid_rst_invalid", 32'(rev_data_invalid), 0);
        check("mid_rst_tx_count", 32'(sif.tx_count), 0);
        check("mid_rst_rx_count", 32'(sif.rx_count), 0);
        @(posedge clk); #1;
        sif.tx_valid = 1'b0; rev_data_valid = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic, fast consumer
        run_random(1500, 80);
        wait_tx_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
